vec_mem_agu: RTL
================

Name: vec_mem_agu

Overview:
Vector load/store address generator that sits directly upstream of the AXI memory queue. It accepts one vector memory command at a time (base, byte stride, beat count, load/store). For loads it emits a back-to-back stream of per-beat address requests. For stores it pairs store data from the vector register read path with addresses and marks the first beat. It then waits for the queue's completion strobe and reports command completion to the vector issue stage.

Parameters:
ADDR_WIDTH, 32, address width of the queue interface
DATA_WIDTH, 64, beat width (two 32-bit bus words per beat)
DW_B, DATA_WIDTH>>3, byte-enable width
LEN_BITS, 9, width of the beat count; must match the queue FIFO depth bits

Ports:
clk  in  1  clock
rst_n  in  1  reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_store  in  1  1=store, 0=load
cmd_base  in  ADDR_WIDTH  byte address of beat 0
cmd_stride  in  ADDR_WIDTH  two's-complement byte stride between beats
cmd_len  in  LEN_BITS  number of beats; 0 = no-op
st_data  in  DATA_WIDTH  store beat data
st_valid  in  1  store beat offered
st_ready  out  1  store beat accepted
mq_addr  out  ADDR_WIDTH  beat address to queue
mq_req  out  1  load beat request
mq_data  out  DATA_WIDTH  store beat data to queue
mq_valid  out  1  store beat valid
mq_start  out  1  first store beat of command
mq_be  out  DW_B  byte enables
mq_done_ld  in  1  queue: load burst delivered
mq_done_st  in  1  queue: all store acks received
busy  out  1  command in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset is decided: rst_n, synchronous, active-low; clock clk. With rst_n low at a clock edge, the next cycle has state=IDLE, all counters 0, and outputs mq_req=mq_valid=mq_start=done=busy=0, mq_addr=0, mq_data=0.
- cmd_ready is high only in IDLE. mq_be is constant all-ones.
- States:
  - IDLE: on accept, go to LD_ISSUE (load), ST_ISSUE (store), or DONE if cmd_len==0.
  - LD_ISSUE: go to LD_WAIT after the last request.
  - LD_WAIT: go to DONE on mq_done_ld.
  - ST_ISSUE: go to ST_WAIT after the last store handshake.
  - ST_WAIT: go to DONE on mq_done_st.
  - DONE: go to IDLE.
- Accept at cycle T latches addr=cmd_base with bits[2:0] forced to 0, stride with bits[2:0] forced to 0, remaining=cmd_len, first=1.
- Address update: addr <= addr + stride, modulo 2^ADDR_WIDTH; wrap-around is silent.
- Loads:
  - mq_req = (state==LD_ISSUE), high in cycles T+1..T+len with no bubbles. The queue detects burst boundaries from contiguous requests.
  - In cycle T+1+i, mq_addr = base + i*stride.
  - remaining decrements each cycle; the state leaves LD_ISSUE when remaining reaches 0.
- Stores:
  - st_ready = (state==ST_ISSUE) & (remaining!=0).
  - On each handshake (st_valid & st_ready), on the next cycle: mq_valid=1, mq_data=st_data, mq_addr=current addr, mq_start=first. Then first<=0, addr advances, remaining decrements.
  - With no handshake, mq_valid and mq_start are 0 next cycle. Gaps are allowed.
- done pulses for exactly the one cycle the block is in DONE; busy = (state!=IDLE).
- Load latency: for a load accepted at T, done is at the cycle after mq_done_ld is sampled.
- mq_done_ld / mq_done_st are ignored in every state other than LD_WAIT / ST_WAIT respectively.
- cmd_len==0: no mq traffic; done pulses at T+1.
- cmd_len at maximum (2^LEN_BITS-1): all beats issued; the counter must not wrap.
- Reset mid-command: the command is abandoned with no done pulse. The queue is reset by the same rst_n.
- cmd_valid held in non-IDLE states is not accepted and has no effect.

Test Plan:
- Load, base 0x1000, stride 8, len 4: mq_req high 4 consecutive cycles with mq_addr 0x1000,0x1008,0x1010,0x1018. busy stays 1 through LD_WAIT. Assert mq_done_ld at cycle 10 -> done=1 at cycle 11 only, cmd_ready=1 at 12.
- Store, base 0x2000, stride 16, len 3, st_valid pattern 1,0,1,1 with data A,B,C: mq_valid 3 pulses with data A,B,C at 0x2000,0x2010,0x2020. mq_start only with A. st_ready drops after C. done on the cycle after mq_done_st.
- Load, base 0x8, stride 0xFFFFFFF8 (-8), len 3: addresses 0x8, 0x0, 0xFFFFFFF8. Base 0x1003 is issued as 0x1000.
- cmd_len=0 store: no mq_valid or st_ready; done at T+1. A back-to-back second command is accepted at T+2.
- Spurious mq_done_st during ST_ISSUE: ignored and no early done. mq_done_ld during a store command: ignored.
- rst_n low during LD_ISSUE after 2 of 5 requests: mq_req=0 and busy=0 the next cycle, no done, and a new command is accepted afterward starting at its own base.

Source files
------------

// File: rtl/vec_mem_agu.sv
// rtl/vec_mem_agu.sv - vector load/store address generator feeding the AXI memory queue
//
// Purpose:
//   Accepts one vector memory command at a time. Loads become a contiguous run
//   of per-beat address requests; stores pair incoming register-file beats
//   with addresses. After issue it waits for the queue's completion strobe and
//   reports completion with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cmd_valid / cmd_ready   command handshake (ready only when idle)
//   cmd_store               1 = store, 0 = load
//   cmd_base, cmd_stride    byte base and signed byte stride (8-byte aligned internally)
//   cmd_len                 beat count, 0 = no-op
//   st_data/st_valid/st_ready  store beat input from the register read path
//   mq_addr                 beat address to the queue
//   mq_req                  load beat request
//   mq_data/mq_valid/mq_start  store beat to the queue, start marks the first beat
//   mq_be                   byte enables (always all ones)
//   mq_done_ld, mq_done_st  queue completion strobes
//   busy, done              command in progress / one-cycle completion pulse

module vec_mem_agu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DW_B       = DATA_WIDTH >> 3,
  parameter int LEN_BITS   = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_store,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  input  logic [LEN_BITS-1:0]   cmd_len,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  st_valid,
  output logic                  st_ready,
  output logic [ADDR_WIDTH-1:0] mq_addr,
  output logic                  mq_req,
  output logic [DATA_WIDTH-1:0] mq_data,
  output logic                  mq_valid,
  output logic                  mq_start,
  output logic [DW_B-1:0]       mq_be,
  input  logic                  mq_done_ld,
  input  logic                  mq_done_st,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_ISSUE,
    S_LD_WAIT,
    S_ST_ISSUE,
    S_ST_WAIT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;      // address of the next beat to issue
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [LEN_BITS-1:0]   r_rem;       // beats still to issue
  logic                  r_first;
  logic [ADDR_WIDTH-1:0] r_st_addr;   // address presented with the last store beat
  logic [DATA_WIDTH-1:0] r_mq_data;
  logic                  r_mq_valid;
  logic                  r_mq_start;

  logic                  w_st_ready;
  logic                  w_st_hs;
  logic                  w_last;

  assign w_st_ready = (r_state == S_ST_ISSUE) && (r_rem != '0);
  assign w_st_hs    = st_valid && w_st_ready;
  assign w_last     = (r_rem == LEN_BITS'(1));

  assign cmd_ready = (r_state == S_IDLE);
  assign st_ready  = w_st_ready;
  assign mq_req    = (r_state == S_LD_ISSUE);
  // Loads present the running address directly so requests are back-to-back;
  // stores present the address captured alongside the registered data beat.
  assign mq_addr   = (r_state == S_LD_ISSUE) ? r_addr : r_st_addr;
  assign mq_data   = r_mq_data;
  assign mq_valid  = r_mq_valid;
  assign mq_start  = r_mq_start;
  assign mq_be     = '1;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_stride   <= '0;
      r_rem      <= '0;
      r_first    <= 1'b0;
      r_st_addr  <= '0;
      r_mq_data  <= '0;
      r_mq_valid <= 1'b0;
      r_mq_start <= 1'b0;
    end else begin
      r_mq_valid <= 1'b0;
      r_mq_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr   <= {cmd_base[ADDR_WIDTH-1:3], 3'b000};
            r_stride <= {cmd_stride[ADDR_WIDTH-1:3], 3'b000};
            r_rem    <= cmd_len;
            r_first  <= 1'b1;
            if (cmd_len == '0)
              r_state <= S_DONE;
            else if (cmd_store)
              r_state <= S_ST_ISSUE;
            else
              r_state <= S_LD_ISSUE;
          end
        end
        S_LD_ISSUE: begin
          r_addr <= r_addr + r_stride;
          r_rem  <= r_rem - LEN_BITS'(1);
          if (w_last)
            r_state <= S_LD_WAIT;
        end
        S_LD_WAIT: begin
          if (mq_done_ld)
            r_state <= S_DONE;
        end
        S_ST_ISSUE: begin
          if (w_st_hs) begin
            r_mq_valid <= 1'b1;
            r_mq_data  <= st_data;
            r_st_addr  <= r_addr;
            r_mq_start <= r_first;
            r_first    <= 1'b0;
            r_addr     <= r_addr + r_stride;
            r_rem      <= r_rem - LEN_BITS'(1);
            if (w_last)
              r_state <= S_ST_WAIT;
          end
        end
        S_ST_WAIT: begin
          if (mq_done_st)
            r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
